// File: rtl/sys_arr_nxn.sv
// sys_arr_nxn: NxN output-stationary systolic array computing C = A*B.
//
// A start request in IDLE captures both operand matrices and clears the
// accumulators. The array then runs 3N-2 steps in which A values travel
// right along each row and B values travel down each column. Values enter
// the left and top edges already skewed, so PE(i,j) meets A[i][k] and
// B[k][j] at step k+i+j. Each PE accumulates the full 2*DW-bit signed
// product, sign-extended to AW bits. Accumulation wraps modulo 2^AW.
//
// Parameters:
//   N   array dimension (2..8)
//   DW  signed operand width
//   AW  signed accumulator width (must be >= 2*DW)
//
// Optional build macro:
//   SYS_ARR_ACCUM_EN  adds the 'accumulate' input. When it is high on the
//                     start-accepting edge, the accumulators keep their
//                     value and the result becomes C_prev + A*B.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   start       compute request, sampled only in IDLE
//   flat_A      A[i][k] at bits [(i*N+k)*DW +: DW]
//   flat_B      B[k][j] at bits [(k*N+j)*DW +: DW]
//   flat_C      C[i][j] at bits [(i*N+j)*AW +: AW]; live accumulator view
//   busy        high from the first step result through the last RUN cycle
//   done        one-cycle pulse when flat_C holds the final product
//   accumulate  (SYS_ARR_ACCUM_EN only) keep previous C on start
module sys_arr_nxn #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N*N*DW-1:0] flat_A,
    input  logic [N*N*DW-1:0] flat_B,
    output logic [N*N*AW-1:0] flat_C,
    output logic              busy,
    output logic              done
`ifdef SYS_ARR_ACCUM_EN
    ,
    input  logic              accumulate
`endif
);

    if (AW < 2*DW) begin : g_aw_check
        $error("sys_arr_nxn: AW must be at least 2*DW");
    end
    if (N < 2 || N > 8) begin : g_n_check
        $error("sys_arr_nxn: N must be in 2..8");
    end

    localparam int unsigned STEPS = 3*N - 2;
    localparam int unsigned LAST  = STEPS - 1;
    localparam int          SW    = $clog2(STEPS);
    localparam int          PW    = 2*DW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [SW-1:0]         step;

    logic signed [DW-1:0]  a_op   [N][N];
    logic signed [DW-1:0]  b_op   [N][N];
    logic signed [DW-1:0]  a_pipe [N][N];
    logic signed [DW-1:0]  b_pipe [N][N];
    logic signed [DW-1:0]  a_in   [N][N];
    logic signed [DW-1:0]  b_in   [N][N];
    logic signed [PW-1:0]  mul    [N][N];
    logic signed [AW-1:0]  prod   [N][N];
    logic [AW-1:0]         acc    [N][N];
    logic                  clear_on_start;

`ifdef SYS_ARR_ACCUM_EN
    always_comb clear_on_start = !accumulate;
`else
    always_comb clear_on_start = 1'b1;
`endif

    // Edge feeds implement the input skew. Row i gets A[i][step-i], and
    // column j gets B[step-j][j]. Out-of-range indices feed zero, so the
    // product contributes nothing. Interior PEs take the value their
    // neighbour held one step earlier.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                a_in[i][j] = '0;
                b_in[i][j] = '0;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (32'(step) == i + k) begin
                    a_in[i][0] = a_op[i][k];
                end
            end
            for (int unsigned j = 1; j < N; j++) begin
                a_in[i][j] = a_pipe[i][j-1];
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (32'(step) == j + k) begin
                    b_in[0][j] = b_op[k][j];
                end
            end
            for (int unsigned i = 1; i < N; i++) begin
                b_in[i][j] = b_pipe[i-1][j];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                mul[i][j]  = PW'(a_in[i][j]) * PW'(b_in[i][j]);
                prod[i][j] = AW'(mul[i][j]);
            end
        end
    end

    always_comb begin
        flat_C = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                flat_C[(i*N+j)*AW +: AW] = acc[i][j];
            end
        end
    end

    // The first RUN cycle has no step result yet, so busy rises one edge
    // after entering RUN. done follows the edge that commits the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    a_op[i][j]   <= '0;
                    b_op[i][j]   <= '0;
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        step  <= '0;
                        for (int unsigned i = 0; i < N; i++) begin
                            for (int unsigned j = 0; j < N; j++) begin
                                a_op[i][j]   <= flat_A[(i*N+j)*DW +: DW];
                                b_op[i][j]   <= flat_B[(i*N+j)*DW +: DW];
                                a_pipe[i][j] <= '0;
                                b_pipe[i][j] <= '0;
                                if (clear_on_start) begin
                                    acc[i][j] <= '0;
                                end
                            end
                        end
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        for (int unsigned j = 0; j < N; j++) begin
                            acc[i][j]    <= acc[i][j] + prod[i][j];
                            a_pipe[i][j] <= a_in[i][j];
                            b_pipe[i][j] <= b_in[i][j];
                        end
                    end
                    if (step == SW'(LAST)) begin
                        state <= DONE;
                        step  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        step  <= step + SW'(1);
                        busy  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
